event_replay_driver: RTL

//  Drives a watched signal from a queued list of (value, delay) events; the inverse of the

---
 rtl/replay_pkg.sv | 7 +
 rtl/replay_fifo.sv | 39 +++
 rtl/event_replay_driver.sv | 95 +++++++++
 3 files changed

// File: rtl/replay_pkg.sv
// replay_pkg: shared FSM encoding and default widths for the event replay driver
package replay_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, FINISH} state_t;
  localparam int DATA_W_DEF = 11;
  localparam int TS_W_DEF = 16;
  localparam int DEPTH_DEF = 8;
endpackage

// File: rtl/replay_fifo.sv
// replay_fifo: synchronous FIFO of {delta,data} events with wrapping pointers
module replay_fifo #(
  parameter int W = 27,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign rdata = mem[rd_ptr];
  // pointer and occupancy tracking; a pop frees its slot only after this edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  // storage array, left unreset since occupancy gates every read
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/event_replay_driver.sv
// event_replay_driver: replays queued (value,delay) events onto out_value; REPLAY_TIMESTAMP_EN adds out_time
module event_replay_driver
  import replay_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TS_W-1:0]   in_delta,
  input  logic              start,
  output logic [DATA_W-1:0] out_value,
  output logic              out_apply,
  output logic              out_changed,
  output logic              busy,
`ifdef REPLAY_TIMESTAMP_EN
  output logic [TS_W+8-1:0] out_time,
`endif
  output logic              done
);
  state_t state, state_nxt;
  logic [TS_W-1:0] cnt, head_delta;
  logic [DATA_W-1:0] value, head_data;
  logic full, empty, pop, apply, launch;
  replay_fifo #(.W(TS_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .pop(pop),
    .wdata({in_delta, in_data}),
    .rdata({head_delta, head_data}),
    .full(full),
    .empty(empty)
  );
  assign in_ready = !full;
  assign apply = state == WAIT && cnt == '0;
  assign launch = state == IDLE && start;
  // next-state and pop decision; the apply cycle also fetches the following event
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    unique case (state)
      IDLE: state_nxt = start ? FETCH : IDLE;
      FETCH: begin
        pop = !empty;
        state_nxt = empty ? FINISH : WAIT;
      end
      WAIT: begin
        pop = apply && !empty;
        state_nxt = apply && empty ? FINISH : WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // delay counter, latched event and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      value <= '0;
      out_value <= '0;
      out_apply <= 1'b0;
      out_changed <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      out_apply <= apply;
      out_changed <= apply && value != out_value;
      if (apply) out_value <= value;
      if (pop) {cnt, value} <= {head_delta, head_data};
      else if (state == WAIT && cnt != '0) cnt <= cnt - TS_W'(1);
      if (launch) begin
        busy <= 1'b1;
        done <= 1'b0;
      end
      if (state == FINISH) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
`ifdef REPLAY_TIMESTAMP_EN
  // saturating start-relative cycle count, frozen while idle
  always_ff @(posedge clk or posedge rst)
    if (rst) out_time <= '0;
    else if (launch) out_time <= '0;
    else if (state != IDLE && out_time != '1) out_time <= out_time + (TS_W+8)'(1);
`endif
endmodule
